// File: rtl/ls_seq_pkg.sv
// Shared state encodings, opcode/ALU constants and the strobe decode for ls_sequencer.
package ls_seq_pkg;

    typedef enum logic [3:0] {
        ST_IDLE = 4'd0,
        ST_F0   = 4'd1,
        ST_F1   = 4'd2,
        ST_F2   = 4'd3,
        ST_E3   = 4'd4,
        ST_E4   = 4'd5,
        ST_E5   = 4'd6,
        ST_E6   = 4'd7,
        ST_E7   = 4'd8,
        ST_HALT = 4'd9,
        ST_ERR  = 4'd10
    } state_e;

    localparam logic [4:0] OPC_LD   = 5'b00000;
    localparam logic [4:0] OPC_LDI  = 5'b00001;
    localparam logic [4:0] OPC_ST   = 5'b00010;
    localparam logic [4:0] OPC_HALT = 5'b11011;

    localparam logic [3:0] ALU_NOP = 4'd0;
    localparam logic [3:0] ALU_ADD = 4'd1;

    localparam int MEM_WAIT_MAX_DEF = 15;

    typedef struct packed {
        logic       pc_out;
        logic       zlo_out;
        logic       mdr_out;
        logic       c_out;
        logic       ba_out;
        logic       r_out;
        logic       mar_in;
        logic       pc_in;
        logic       mdr_in;
        logic       ir_in;
        logic       y_in;
        logic       z_in;
        logic       r_in;
        logic       inc_pc;
        logic       gra;
        logic       grb;
        logic       read;
        logic       write;
        logic [3:0] alu_op;
    } strobes_t;

    // Strobe pattern for one state; the E5..E7 patterns depend on the latched instruction class.
    function automatic strobes_t decode_strobes(input state_e st, input logic is_ldi,
                                                input logic is_st, input logic f1_first);
        strobes_t s;
        s        = '0;
        s.alu_op = ALU_NOP;
        case (st)
            ST_F0: begin
                s.pc_out = 1'b1; s.mar_in = 1'b1; s.inc_pc = 1'b1; s.z_in = 1'b1;
            end
            ST_F1: begin
                s.zlo_out = 1'b1; s.pc_in = f1_first; s.read = 1'b1; s.mdr_in = 1'b1;
            end
            ST_F2: begin
                s.mdr_out = 1'b1; s.ir_in = 1'b1;
            end
            ST_E3: begin
                s.grb = 1'b1; s.ba_out = 1'b1; s.y_in = 1'b1;
            end
            ST_E4: begin
                s.c_out = 1'b1; s.z_in = 1'b1; s.alu_op = ALU_ADD;
            end
            ST_E5: begin
                s.zlo_out = 1'b1;
                if (is_ldi) begin
                    s.gra = 1'b1; s.r_in = 1'b1;
                end else begin
                    s.mar_in = 1'b1;
                end
            end
            ST_E6: begin
                if (is_st) begin
                    s.gra = 1'b1; s.r_out = 1'b1; s.mdr_in = 1'b1;
                end else begin
                    s.read = 1'b1; s.mdr_in = 1'b1;
                end
            end
            ST_E7: begin
                if (is_st) begin
                    s.write = 1'b1;
                end else begin
                    s.mdr_out = 1'b1; s.gra = 1'b1; s.r_in = 1'b1;
                end
            end
            default: s = '0;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive cycles of an outstanding memory access; expired flags the last allowed cycle.
module mem_wait_timer
    import ls_seq_pkg::*;
#(
    parameter int MAX = MEM_WAIT_MAX_DEF
) (
    input  logic clk,
    input  logic clr_n,
    input  logic start,
    input  logic done,
    output logic expired
);

    localparam int CW = $clog2(MAX + 1);

    logic [CW-1:0] cnt_r;

    // Count while the wait is in progress; any other cycle clears it so each memory state starts at zero.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            cnt_r <= '0;
        end else if (start && !done) begin
            cnt_r <= cnt_r + CW'(1);
        end else begin
            cnt_r <= '0;
        end
    end

    assign expired = start && !done && (cnt_r == CW'(MAX - 1));

endmodule

// File: rtl/ls_sequencer.sv
// Hardwired load/store control sequencer (ld, ldi, st, halt) with handshake-held memory states.
// Optional memory-wait timeout is built when LS_SEQ_TIMEOUT_EN is defined.
module ls_sequencer
    import ls_seq_pkg::*;
#(
    parameter int IR_W         = 32,
    parameter int OPC_W        = 5,
    parameter int MEM_WAIT_MAX = MEM_WAIT_MAX_DEF
) (
    input  logic            clk,
    input  logic            clr_n,
    input  logic            run,
    input  logic [IR_W-1:0] ir,
    input  logic            mem_done,
    output logic            pc_out,
    output logic            zlo_out,
    output logic            mdr_out,
    output logic            c_out,
    output logic            ba_out,
    output logic            r_out,
    output logic            mar_in,
    output logic            pc_in,
    output logic            mdr_in,
    output logic            ir_in,
    output logic            y_in,
    output logic            z_in,
    output logic            r_in,
    output logic            inc_pc,
    output logic            gra,
    output logic            grb,
    output logic            read,
    output logic            write,
    output logic [3:0]      alu_op,
    output logic [3:0]      state,
    output logic            halted,
    output logic            err_timeout
);

    state_e           state_r, state_nxt_s;
    logic [OPC_W-1:0] opc_s, opc_r;
    logic             opc_ok_s, is_ldi_s, is_st_s, f1_first_s, expired_s, halted_r;
    strobes_t         strb_r, strb_nxt_s;
    logic             unused_s;

    assign opc_s    = ir[IR_W-1 -: OPC_W];
    assign unused_s = ^ir[IR_W-OPC_W-1:0];
    assign opc_ok_s = (opc_s == OPC_LD) || (opc_s == OPC_LDI) || (opc_s == OPC_ST);
    assign is_ldi_s = (opc_r == OPC_LDI);
    assign is_st_s  = (opc_r == OPC_ST);

`ifdef LS_SEQ_TIMEOUT_EN
    logic mem_wait_s;
    logic err_r;

    assign mem_wait_s = (state_r == ST_F1) || ((state_r == ST_E6) && !is_st_s) ||
                        ((state_r == ST_E7) && is_st_s);

    mem_wait_timer #(.MAX(MEM_WAIT_MAX)) u_mem_wait_timer (
        .clk     (clk),
        .clr_n   (clr_n),
        .start   (mem_wait_s),
        .done    (mem_done),
        .expired (expired_s)
    );

    // Error flag registered alongside the state so it lines up with ERR.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            err_r <= 1'b0;
        end else begin
            err_r <= (state_nxt_s == ST_ERR);
        end
    end

    assign err_timeout = err_r;
`else
    assign expired_s   = 1'b0;
    assign err_timeout = 1'b0;
`endif

    // Next-state logic; mem_done matters only in F1, E6 (ld) and E7 (st).
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: state_nxt_s = run ? ST_F0 : ST_IDLE;
            ST_F0:   state_nxt_s = ST_F1;
            ST_F1: begin
                if (mem_done)       state_nxt_s = ST_F2;
                else if (expired_s) state_nxt_s = ST_ERR;
                else                state_nxt_s = ST_F1;
            end
            ST_F2:   state_nxt_s = opc_ok_s ? ST_E3 : ST_HALT;
            ST_E3:   state_nxt_s = ST_E4;
            ST_E4:   state_nxt_s = ST_E5;
            ST_E5: begin
                if (is_ldi_s) state_nxt_s = run ? ST_F0 : ST_IDLE;
                else          state_nxt_s = ST_E6;
            end
            ST_E6: begin
                if (is_st_s || mem_done) state_nxt_s = ST_E7;
                else if (expired_s)      state_nxt_s = ST_ERR;
                else                     state_nxt_s = ST_E6;
            end
            ST_E7: begin
                if (!is_st_s || mem_done) state_nxt_s = run ? ST_F0 : ST_IDLE;
                else if (expired_s)       state_nxt_s = ST_ERR;
                else                      state_nxt_s = ST_E7;
            end
            ST_HALT: state_nxt_s = ST_HALT;
            ST_ERR:  state_nxt_s = ST_ERR;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Registered strobes equal the decode of the current state; the pc_in register acts as the f1_first flag.
    assign f1_first_s = (state_nxt_s == ST_F1) && (state_r != ST_F1);
    assign strb_nxt_s = decode_strobes(state_nxt_s, is_ldi_s, is_st_s, f1_first_s);

    // State, opcode latched at the end of F2, and registered outputs.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r  <= ST_IDLE;
            opc_r    <= '0;
            strb_r   <= '0;
            halted_r <= 1'b0;
        end else begin
            state_r  <= state_nxt_s;
            strb_r   <= strb_nxt_s;
            halted_r <= (state_nxt_s == ST_HALT);
            if (state_r == ST_F2) begin
                opc_r <= opc_s;
            end else begin
                opc_r <= opc_r;
            end
        end
    end

    assign state   = state_r;
    assign halted  = halted_r;
    assign pc_out  = strb_r.pc_out;
    assign zlo_out = strb_r.zlo_out;
    assign mdr_out = strb_r.mdr_out;
    assign c_out   = strb_r.c_out;
    assign ba_out  = strb_r.ba_out;
    assign r_out   = strb_r.r_out;
    assign mar_in  = strb_r.mar_in;
    assign pc_in   = strb_r.pc_in;
    assign mdr_in  = strb_r.mdr_in;
    assign ir_in   = strb_r.ir_in;
    assign y_in    = strb_r.y_in;
    assign z_in    = strb_r.z_in;
    assign r_in    = strb_r.r_in;
    assign inc_pc  = strb_r.inc_pc;
    assign gra     = strb_r.gra;
    assign grb     = strb_r.grb;
    assign read    = strb_r.read;
    assign write   = strb_r.write;
    assign alu_op  = strb_r.alu_op;

endmodule

// File: tb/tb_ls_sequencer.sv
// Scoreboard bench for ls_sequencer: each issued instruction expands into its expected per-cycle trace.
`timescale 1ns/1ps
module tb_ls_sequencer;

    logic        clk   = 1'b0;
    logic        clr_n = 1'b1;
    logic        run, mem_done;
    logic [31:0] ir;
    logic        pc_out, zlo_out, mdr_out, c_out, ba_out, r_out, mar_in, pc_in, mdr_in, ir_in;
    logic        y_in, z_in, r_in, inc_pc, gra, grb, read, write, halted, err_timeout;
    logic [3:0]  alu_op, state;

    ls_sequencer #(.IR_W(32), .OPC_W(5), .MEM_WAIT_MAX(4)) dut (
        .clk(clk), .clr_n(clr_n), .run(run), .ir(ir), .mem_done(mem_done),
        .pc_out(pc_out), .zlo_out(zlo_out), .mdr_out(mdr_out), .c_out(c_out), .ba_out(ba_out),
        .r_out(r_out), .mar_in(mar_in), .pc_in(pc_in), .mdr_in(mdr_in), .ir_in(ir_in),
        .y_in(y_in), .z_in(z_in), .r_in(r_in), .inc_pc(inc_pc), .gra(gra), .grb(grb),
        .read(read), .write(write), .alu_op(alu_op), .state(state), .halted(halted),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    localparam logic [17:0] PC_OUT = 18'h20000, ZLO_OUT = 18'h10000, MDR_OUT = 18'h08000;
    localparam logic [17:0] C_OUT  = 18'h04000, BA_OUT  = 18'h02000, R_OUT   = 18'h01000;
    localparam logic [17:0] MAR_IN = 18'h00800, PC_IN   = 18'h00400, MDR_IN  = 18'h00200;
    localparam logic [17:0] IR_IN  = 18'h00100, Y_IN    = 18'h00080, Z_IN    = 18'h00040;
    localparam logic [17:0] R_IN   = 18'h00020, INC_PC  = 18'h00010, GRA     = 18'h00008;
    localparam logic [17:0] GRB    = 18'h00004, RD      = 18'h00002, WR      = 18'h00001;
    localparam logic [3:0]  A_NOP = 4'd0, A_ADD = 4'd1;
    localparam logic [4:0]  OP_LD = 5'b00000, OP_LDI = 5'b00001, OP_ST = 5'b00010, OP_HALT = 5'b11011;

    logic [27:0] obs;
    assign obs = {state, halted, err_timeout, alu_op, pc_out, zlo_out, mdr_out, c_out, ba_out, r_out,
                  mar_in, pc_in, mdr_in, ir_in, y_in, z_in, r_in, inc_pc, gra, grb, read, write};

    logic [27:0] exp_q[$];
    logic [27:0] mon_e;
    int          n_vec  = 0;
    int          n_mis  = 0;
    bit          mon_on = 1'b0;

    function automatic logic [27:0] mk(input logic [3:0] st, input logic [17:0] s, input logic [3:0] alu);
        return {st, (st == 4'd9), (st == 4'd10), alu, s};
    endfunction

    function automatic logic rb();
        return 1'($urandom_range(0, 1));
    endfunction

    // Monitor: every cycle the DUT presents a Moore output, compared against the oldest expectation.
    always @(negedge clk) begin
        if (mon_on) begin
            n_vec++;
            if (exp_q.size() == 0) begin
                if (state != 4'd0) begin
                    n_mis++;
                    $display("FAIL unexpected_activity @%0t: state %0d, expected 0", $time, state);
                end
            end else begin
                mon_e = exp_q.pop_front();
                if (obs !== mon_e) begin
                    n_mis++;
                    $display("FAIL trace @%0t: outputs %h (state %0d), expected %h (state %0d)",
                             $time, obs, obs[27:24], mon_e, mon_e[27:24]);
                end
            end
        end
    end

    task automatic do_cycle(input logic md, input logic rn, input logic [31:0] irv, input logic [27:0] e);
        @(posedge clk);
        #1;
        mem_done = md;
        run      = rn;
        ir       = irv;
        exp_q.push_back(e);
    endtask

    task automatic pulse_reset();
        @(posedge clk);
        #1;
        run = 1'b0;
        exp_q.push_back(mk(4'd0, 18'd0, A_NOP));
        #2;
        clr_n = 1'b0;
        #1;
        n_vec++;
        if (obs !== 28'd0) begin
            n_mis++;
            $display("FAIL async_reset @%0t: outputs %h, expected 0", $time, obs);
        end
        @(posedge clk);
        #1;
        clr_n = 1'b1;
        exp_q.push_back(mk(4'd0, 18'd0, A_NOP));
    endtask

    // Expand one instruction into its cycle-by-cycle expected trace while driving its inputs.
    task automatic run_instr(input logic [4:0] opc, input int w1, input int w2, input logic end_run,
                             input bit abort);
        logic [31:0] iw;
        iw = {opc, 27'($urandom)};
        do_cycle(rb(), rb(), iw, mk(4'd1, PC_OUT | MAR_IN | INC_PC | Z_IN, A_NOP));
        for (int i = 0; i <= w1; i++)
            do_cycle(i == w1, rb(), iw, mk(4'd2, ZLO_OUT | RD | MDR_IN | ((i == 0) ? PC_IN : 18'd0), A_NOP));
        do_cycle(rb(), rb(), iw, mk(4'd3, MDR_OUT | IR_IN, A_NOP));
        if (opc != OP_LD && opc != OP_LDI && opc != OP_ST) begin
            for (int i = 0; i < 4; i++) do_cycle(rb(), rb(), $urandom, mk(4'd9, 18'd0, A_NOP));
            return;
        end
        do_cycle(rb(), rb(), $urandom, mk(4'd4, GRB | BA_OUT | Y_IN, A_NOP));
        do_cycle(rb(), rb(), $urandom, mk(4'd5, C_OUT | Z_IN, A_ADD));
        if (opc == OP_LDI) begin
            do_cycle(rb(), end_run, $urandom, mk(4'd6, ZLO_OUT | GRA | R_IN, A_NOP));
            return;
        end
        do_cycle(rb(), rb(), $urandom, mk(4'd6, ZLO_OUT | MAR_IN, A_NOP));
        if (opc == OP_LD) begin
            for (int i = 0; i <= w2; i++) begin
                if (abort && i == 1) begin
                    pulse_reset();
                    return;
                end
                do_cycle(i == w2, rb(), $urandom, mk(4'd7, RD | MDR_IN, A_NOP));
            end
            do_cycle(rb(), end_run, $urandom, mk(4'd8, MDR_OUT | GRA | R_IN, A_NOP));
        end else begin
            do_cycle(rb(), rb(), $urandom, mk(4'd7, GRA | R_OUT | MDR_IN, A_NOP));
            for (int i = 0; i <= w2; i++)
                do_cycle(i == w2, (i == w2) ? end_run : rb(), $urandom, mk(4'd8, WR, A_NOP));
        end
    endtask

    initial begin
        logic [4:0] opc;
        int         sel;
        logic       er;
        clr_n    = 1'b0;
        run      = 1'b0;
        mem_done = 1'b0;
        ir       = 32'd0;
        #3;
        n_vec++;
        if (obs !== 28'd0) begin
            n_mis++;
            $display("FAIL reset_state: outputs %h, expected 0", obs);
        end
        @(posedge clk);
        #1;
        clr_n  = 1'b1;
        mon_on = 1'b1;
        exp_q.push_back(mk(4'd0, 18'd0, A_NOP));
        do_cycle(1'b0, 1'b1, 32'd0, mk(4'd0, 18'd0, A_NOP));

        run_instr(OP_LDI, 0, 0, 1'b1, 1'b0);
        run_instr(OP_LD, 0, 3, 1'b1, 1'b0);
        run_instr(OP_ST, 0, 0, 1'b1, 1'b0);

        for (int k = 0; k < 40; k++) begin
            sel = $urandom_range(0, 2);
            opc = (sel == 0) ? OP_LD : ((sel == 1) ? OP_LDI : OP_ST);
            er  = ($urandom_range(0, 3) != 0);
            run_instr(opc, $urandom_range(0, 3), $urandom_range(0, 3), er, 1'b0);
            if (!er) begin
                repeat ($urandom_range(0, 2)) do_cycle(rb(), 1'b0, $urandom, mk(4'd0, 18'd0, A_NOP));
                do_cycle(rb(), 1'b1, $urandom, mk(4'd0, 18'd0, A_NOP));
            end
        end

        run_instr(OP_LD, 1, 3, 1'b1, 1'b1);
        do_cycle(rb(), 1'b1, 32'd0, mk(4'd0, 18'd0, A_NOP));
        run_instr(OP_LDI, 0, 0, 1'b1, 1'b0);
        run_instr(OP_HALT, 1, 0, 1'b1, 1'b0);
        pulse_reset();
        do_cycle(rb(), 1'b1, 32'd0, mk(4'd0, 18'd0, A_NOP));
        run_instr(5'b10101, 0, 0, 1'b1, 1'b0);
        pulse_reset();

`ifdef LS_SEQ_TIMEOUT_EN
        do_cycle(1'b0, 1'b1, 32'd0, mk(4'd0, 18'd0, A_NOP));
        do_cycle(1'b0, 1'b1, 32'd0, mk(4'd1, PC_OUT | MAR_IN | INC_PC | Z_IN, A_NOP));
        for (int i = 0; i < 4; i++)
            do_cycle(1'b0, 1'b1, 32'd0, mk(4'd2, ZLO_OUT | RD | MDR_IN | ((i == 0) ? PC_IN : 18'd0), A_NOP));
        repeat (3) do_cycle(rb(), rb(), $urandom, mk(4'd10, 18'd0, A_NOP));
        pulse_reset();
`endif

        do_cycle(1'b0, 1'b0, 32'd0, mk(4'd0, 18'd0, A_NOP));
        @(posedge clk);
        #1;
        n_vec++;
        if (exp_q.size() != 0) begin
            n_mis++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
